// File: rtl/cntr_seq_ctrl_if.sv
// Command channel between the upstream pin decoder and the counter sequencer.
// One command word is transferred per cycle in which cmd_valid and cmd_ready
// are both high.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : sequencer can take a command this cycle (slave -> master)
//   cmd_op    : 3-bit opcode (master -> slave)
//   cmd_arg   : WIDTH-bit operand (master -> slave)
interface cntr_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cntr_seq_ctrl.sv
// Command-driven sequencer for the counter datapath. It owns the counter's
// load / enable / direction controls, watches the counter's registered value
// and runs a configured number of periods from a start value to a limit value.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   cmd          : command channel (slave side), ready is low in LOAD and in reset
//   cnt_value    : current registered counter value from the datapath
//   cnt_load     : datapath loads cnt_load_val at the next edge
//   cnt_load_val : start register
//   cnt_en       : datapath steps by +/-1 at the next edge (combinational)
//   cnt_up       : direction register (1 = up)
//   busy         : high in LOAD, RUN and PAUSE
//   done         : one-cycle pulse on the first cycle of DONE
//   err          : one-cycle pulse the cycle after an illegal command is taken
//   period_cnt   : completed periods since the last GO
//   state        : IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
// The SET_REPEAT operand is taken from cmd_arg[7:0], so WIDTH must be >= 8.
module cntr_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  cntr_seq_ctrl_if.slave   cmd,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       period_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SET_START  = 3'd1;
  localparam logic [2:0] OP_SET_LIMIT  = 3'd2;
  localparam logic [2:0] OP_SET_REPEAT = 3'd3;
  localparam logic [2:0] OP_SET_DIR    = 3'd4;
  localparam logic [2:0] OP_GO         = 3'd5;
  localparam logic [2:0] OP_STOP       = 3'd6;
  localparam logic [2:0] OP_PAUSE      = 3'd7;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [7:0]       rpt_q, rpt_d;
  logic             dir_q, dir_d;
  logic [7:0]       period_cnt_q, period_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cmd_ready_w;
  logic             accept;
  logic             idle_like;
  logic             match;
  logic [7:0]       period_nxt;

  // LOAD is the only state that refuses commands, which keeps the one-cycle
  // load pulse atomic.
  assign cmd_ready_w = ~rst & (state_q != ST_LOAD);
  assign cmd.cmd_ready = cmd_ready_w;
  assign accept      = cmd.cmd_valid & cmd_ready_w;
  assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign match       = (state_q == ST_RUN) && (cnt_value == limit_q);
  assign period_nxt  = period_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    limit_d      = limit_q;
    rpt_d        = rpt_q;
    dir_d        = dir_q;
    period_cnt_d = period_cnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (state_q == ST_LOAD) begin
      state_d = ST_RUN;
    end else if (accept) begin
      // Any accepted command in RUN takes precedence over a same-cycle match.
      // The counter was not enabled on a match cycle, so the match is simply
      // seen again on the next RUN cycle.
      unique case (cmd.cmd_op)
        OP_SET_START: if (idle_like) start_d = cmd.cmd_arg;
                      else           err_d   = 1'b1;
        OP_SET_LIMIT: if (idle_like) limit_d = cmd.cmd_arg;
                      else           err_d   = 1'b1;
        OP_SET_REPEAT: if (idle_like) rpt_d  = cmd.cmd_arg[7:0];
                       else           err_d  = 1'b1;
        OP_SET_DIR:   if (idle_like) dir_d   = cmd.cmd_arg[0];
                      else           err_d   = 1'b1;
        OP_GO: begin
          if (idle_like) begin
            period_cnt_d = 8'd0;
            state_d      = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STOP: state_d = ST_IDLE;
        OP_PAUSE: begin
          if (state_q == ST_RUN)        state_d = ST_PAUSE;
          else if (state_q == ST_PAUSE) state_d = ST_RUN;
          else                          err_d   = 1'b1;
        end
        OP_NOP: ;
        default: ;
      endcase
    end else if (match) begin
      // Repeat of zero never terminates; the 8-bit period count wraps.
      period_cnt_d = period_nxt;
      if ((rpt_q != 8'd0) && (period_nxt == rpt_q)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      limit_q      <= '1;
      rpt_q        <= 8'd1;
      dir_q        <= 1'b1;
      period_cnt_q <= 8'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      limit_q      <= limit_d;
      rpt_q        <= rpt_d;
      dir_q        <= dir_d;
      period_cnt_q <= period_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cnt_load     = (state_q == ST_LOAD);
  assign cnt_load_val = start_q;
  // Enable stops exactly on the limit so the counter parks there for the
  // match cycle (and stays there if the match is deferred by a command).
  assign cnt_en       = (state_q == ST_RUN) && (cnt_value != limit_q);
  assign cnt_up       = dir_q;
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done         = done_q;
  assign err          = err_q;
  assign period_cnt   = period_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Directed testbench for cntr_seq_ctrl. Includes a behavioural model of the
// counter datapath (load / step +-1 modulo 2^WIDTH) driven by the DUT controls.
module tb_cntr_seq_ctrl;
  localparam int W = 8;
  localparam logic [2:0] NOP = 3'd0, SSTART = 3'd1, SLIMIT = 3'd2, SREP = 3'd3,
                         SDIR = 3'd4, GO = 3'd5, STOP = 3'd6, PAUSE = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cnt_value = '0;
  logic         cnt_load, cnt_en, cnt_up, busy, done, err;
  logic [W-1:0] cnt_load_val;
  logic [7:0]   period_cnt;
  logic [2:0]   state;
  int           n_run = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  cntr_seq_ctrl_if #(.WIDTH(W)) cif ();

  cntr_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd(cif), .cnt_value(cnt_value),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .busy(busy), .done(done), .err(err),
    .period_cnt(period_cnt), .state(state)
  );

  // Counter datapath model
  always @(posedge clk) begin
    if (cnt_load)    cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] arg);
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_arg = arg;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0; cif.cmd_op = NOP; cif.cmd_arg = '0;
  endtask

  task automatic configure(input logic [W-1:0] s, input logic [W-1:0] l,
                           input logic [7:0] r, input logic d);
    send_cmd(SSTART, s);
    send_cmd(SLIMIT, l);
    send_cmd(SREP, r);
    send_cmd(SDIR, {7'd0, d});
  endtask

  task automatic test_reset();
    cif.cmd_valid = 1'b0; cif.cmd_op = NOP; cif.cmd_arg = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_run++; if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %0b exp 0", cif.cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", state); end
    n_run++; if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b exp 1", cif.cmd_ready); end
    n_run++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_en: got %0b exp 0", cnt_en); end
    n_run++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_load: got %0b exp 0", cnt_load); end
    n_run++; if (period_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_period_cnt: got %0d exp 0", period_cnt); end
    n_run++; if (cnt_up !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_up: got %0b exp 1", cnt_up); end
    n_run++; if (cnt_load_val !== 8'd0) begin n_fail++; $display("FAIL rst_load_val: got %0d exp 0", cnt_load_val); end
    n_run++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {busy, done, err}); end
    step();
  endtask

  // start 3, limit 7, repeat 2, up: loads at t+1 and t+7, done at t+13
  task automatic test_two_periods();
    logic exp_load, exp_en, exp_done;
    configure(8'd3, 8'd7, 8'd2, 1'b1);
    send_cmd(GO, '0);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_load = (i == 1) || (i == 7);
      exp_en   = (i >= 2 && i <= 5) || (i >= 8 && i <= 11);
      exp_done = (i == 13);
      n_run++; if (cnt_load !== exp_load) begin n_fail++; $display("FAIL two_load c%0d: got %0b exp %0b", i, cnt_load, exp_load); end
      n_run++; if (cnt_en !== exp_en) begin n_fail++; $display("FAIL two_en c%0d: got %0b exp %0b", i, cnt_en, exp_en); end
      n_run++; if (done !== exp_done) begin n_fail++; $display("FAIL two_done c%0d: got %0b exp %0b", i, done, exp_done); end
      if (i == 1) begin
        n_run++; if (cnt_load_val !== 8'd3) begin n_fail++; $display("FAIL two_load_val: got %0d exp 3", cnt_load_val); end
        n_run++; if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL two_ready_in_load: got %0b exp 0", cif.cmd_ready); end
      end
      if (i == 2) begin
        n_run++; if (cnt_value !== 8'd3) begin n_fail++; $display("FAIL two_first_run_val: got %0d exp 3", cnt_value); end
      end
      if (i == 14) begin
        n_run++; if (state !== 3'd4) begin n_fail++; $display("FAIL two_state: got %0d exp 4", state); end
        n_run++; if (period_cnt !== 8'd2) begin n_fail++; $display("FAIL two_period_cnt: got %0d exp 2", period_cnt); end
      end
      step();
    end
  endtask

  // start 2, limit 254, down, repeat 1: 2,1,0,255,254 then done at GO+7
  task automatic test_down_wrap();
    logic [7:0] vals [5];
    logic exp_en;
    vals = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    configure(8'd2, 8'd254, 8'd1, 1'b0);
    send_cmd(GO, '0);
    n_run++; if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL down_dir: got %0b exp 0", cnt_up); end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp_en = (i >= 2 && i <= 5);
      n_run++; if (cnt_en !== exp_en) begin n_fail++; $display("FAIL down_en c%0d: got %0b exp %0b", i, cnt_en, exp_en); end
      n_run++; if (done !== (i == 7)) begin n_fail++; $display("FAIL down_done c%0d: got %0b exp %0b", i, done, (i == 7)); end
      if (i >= 2 && i <= 6) begin
        n_run++; if (cnt_value !== vals[i-2]) begin n_fail++; $display("FAIL down_val c%0d: got %0d exp %0d", i, cnt_value, vals[i-2]); end
      end
      step();
    end
  endtask

  task automatic test_pause_stop();
    bit found;
    // pause mid-run, counter held at 5
    configure(8'd0, 8'd10, 8'd1, 1'b1);
    send_cmd(GO, '0);
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (state == 3'd2 && cnt_value == 8'd4) begin found = 1; break; end
      step();
    end
    n_run++; if (!found) begin n_fail++; $display("FAIL pause_wait4: got timeout exp value 4"); end
    send_cmd(PAUSE, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_run++; if (state !== 3'd3) begin n_fail++; $display("FAIL pause_state h%0d: got %0d exp 3", k, state); end
      n_run++; if (cnt_value !== 8'd5) begin n_fail++; $display("FAIL pause_hold h%0d: got %0d exp 5", k, cnt_value); end
      n_run++; if ({cnt_en, busy} !== 2'b01) begin n_fail++; $display("FAIL pause_en_busy h%0d: got %b exp 01", k, {cnt_en, busy}); end
      step();
    end
    send_cmd(PAUSE, '0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i <= 5) begin
        n_run++; if (cnt_value !== 8'(4 + i)) begin n_fail++; $display("FAIL resume_val c%0d: got %0d exp %0d", i, cnt_value, 4 + i); end
      end
      n_run++; if (cnt_en !== (i <= 5)) begin n_fail++; $display("FAIL resume_en c%0d: got %0b exp %0b", i, cnt_en, (i <= 5)); end
      n_run++; if (done !== (i == 7)) begin n_fail++; $display("FAIL resume_done c%0d: got %0b exp %0b", i, done, (i == 7)); end
      step();
    end
    n_run++; if (period_cnt !== 8'd1) begin n_fail++; $display("FAIL resume_period: got %0d exp 1", period_cnt); end

    // pause on the match cycle: match deferred, counted once after resume
    configure(8'd0, 8'd3, 8'd2, 1'b1);
    send_cmd(GO, '0);
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (state == 3'd2 && cnt_value == 8'd3) begin found = 1; break; end
      step();
    end
    n_run++; if (!found) begin n_fail++; $display("FAIL pmatch_wait: got timeout exp match"); end
    send_cmd(PAUSE, '0);
    @(negedge clk);
    n_run++; if (state !== 3'd3) begin n_fail++; $display("FAIL pmatch_state: got %0d exp 3", state); end
    n_run++; if (period_cnt !== 8'd0) begin n_fail++; $display("FAIL pmatch_period0: got %0d exp 0", period_cnt); end
    send_cmd(PAUSE, '0);
    @(negedge clk);
    n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL pmatch_resume_state: got %0d exp 2", state); end
    n_run++; if (cnt_value !== 8'd3 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL pmatch_resume_val: got %0d/%0b exp 3/0", cnt_value, cnt_en); end
    step();
    @(negedge clk);
    n_run++; if (state !== 3'd1 || cnt_load !== 1'b1) begin n_fail++; $display("FAIL pmatch_reload: got %0d/%0b exp 1/1", state, cnt_load); end
    n_run++; if (period_cnt !== 8'd1) begin n_fail++; $display("FAIL pmatch_period1: got %0d exp 1", period_cnt); end
    step();

    // STOP mid-run: IDLE, period_cnt retained, no done
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (state == 3'd2 && cnt_value == 8'd1) begin found = 1; break; end
      step();
    end
    n_run++; if (!found) begin n_fail++; $display("FAIL stop_wait: got timeout exp value 1"); end
    send_cmd(STOP, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL stop_state h%0d: got %0d exp 0", k, state); end
      n_run++; if ({done, cnt_en, busy} !== 3'b000) begin n_fail++; $display("FAIL stop_flags h%0d: got %b exp 000", k, {done, cnt_en, busy}); end
      n_run++; if (period_cnt !== 8'd1) begin n_fail++; $display("FAIL stop_period h%0d: got %0d exp 1", k, period_cnt); end
      step();
    end
  endtask

  task automatic test_err_in_run();
    configure(8'd0, 8'd6, 8'd1, 1'b1);
    send_cmd(GO, '0);               // cycle 1: LOAD
    step();                         // cycle 2: value 0
    step();                         // cycle 3: value 1
    send_cmd(SLIMIT, 8'd2);         // cycle 4: value 2
    @(negedge clk);
    n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_setlimit: got %0b exp 1", err); end
    n_run++; if (state !== 3'd2 || cnt_value !== 8'd2) begin n_fail++; $display("FAIL err_setlimit_run: got %0d/%0d exp 2/2", state, cnt_value); end
    step();                         // cycle 5
    @(negedge clk);
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len: got %0b exp 0", err); end
    send_cmd(GO, '0);               // cycle 6: value 4
    @(negedge clk);
    n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_go: got %0b exp 1", err); end
    n_run++; if (state !== 3'd2 || cnt_value !== 8'd4 || period_cnt !== 8'd0) begin n_fail++; $display("FAIL err_go_run: got %0d/%0d/%0d exp 2/4/0", state, cnt_value, period_cnt); end
    step();                         // cycle 7
    step();                         // cycle 8: match at original limit 6
    @(negedge clk);
    n_run++; if (cnt_value !== 8'd6 || cnt_en !== 1'b0 || state !== 3'd2) begin n_fail++; $display("FAIL err_match: got %0d/%0b/%0d exp 6/0/2", cnt_value, cnt_en, state); end
    step();                         // cycle 9: DONE
    @(negedge clk);
    n_run++; if (done !== 1'b1 || state !== 3'd4) begin n_fail++; $display("FAIL err_done: got %0b/%0d exp 1/4", done, state); end
    send_cmd(PAUSE, '0);            // illegal in DONE
    @(negedge clk);
    n_run++; if (err !== 1'b1 || done !== 1'b0 || state !== 3'd4) begin n_fail++; $display("FAIL err_pause_done: got %0b/%0b/%0d exp 1/0/4", err, done, state); end
    step();
  endtask

  task automatic test_continuous_and_reset();
    logic [7:0] prev;
    int wrap_i, done_i;
    bit saw_done;
    configure(8'd0, 8'd1, 8'd0, 1'b1);
    send_cmd(GO, '0);
    prev = 8'd0; wrap_i = -1; saw_done = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (state == 3'd4 || done) saw_done = 1;
      if (prev == 8'd255 && period_cnt == 8'd0) begin wrap_i = i; break; end
      prev = period_cnt;
      step();
    end
    n_run++; if (wrap_i != 769) begin n_fail++; $display("FAIL cont_wrap_cycle: got %0d exp 769", wrap_i); end
    n_run++; if (saw_done) begin n_fail++; $display("FAIL cont_no_done: got 1 exp 0"); end
    step();
    @(negedge clk);
    n_run++; if (state !== 3'd2) begin n_fail++; $display("FAIL cont_state: got %0d exp 2", state); end
    rst = 1'b1;
    #1;
    n_run++; if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %0b exp 0", cif.cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_run++; if (state !== 3'd0) begin n_fail++; $display("FAIL mid_rst_state: got %0d exp 0", state); end
    n_run++; if ({cnt_en, cnt_load, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b exp 000", {cnt_en, cnt_load, busy}); end
    n_run++; if (period_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_period: got %0d exp 0", period_cnt); end
    // Reset config: start 0, limit 255, repeat 1, up -> one 257-cycle period
    send_cmd(GO, '0);
    done_i = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_run++; if (cnt_load !== 1'b1 || cnt_load_val !== 8'd0) begin n_fail++; $display("FAIL post_rst_load: got %0b/%0d exp 1/0", cnt_load, cnt_load_val); end
      end
      if (done) begin done_i = i; break; end
      step();
    end
    n_run++; if (done_i != 258) begin n_fail++; $display("FAIL post_rst_done_cycle: got %0d exp 258", done_i); end
    n_run++; if (period_cnt !== 8'd1 || state !== 3'd4) begin n_fail++; $display("FAIL post_rst_final: got %0d/%0d exp 1/4", period_cnt, state); end
    step();
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = NOP; cif.cmd_arg = '0;
    test_reset();
    test_two_periods();
    test_down_wrap();
    test_pause_stop();
    test_err_in_run();
    test_continuous_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
